// File: rtl/cla_pkg.sv
// Shared types and the flat borrow-lookahead function for the lookahead add/sub family.
package cla_pkg;

    localparam int unsigned CLA_W = 8;

    typedef logic [CLA_W-1:0] cla_word_t;

    typedef struct packed {
        cla_word_t g;
        cla_word_t p;
    } cla_gp_t;

    // br[i] is the borrow out of bit i, each a flat sum of g/p products seeded by bin.
    function automatic cla_word_t bla_borrows(input cla_word_t g, input cla_word_t p,
                                              input logic bin);
        cla_word_t br;
        logic      term;
        br = '0;
        for (int i = 0; i < int'(CLA_W); i++) begin
            term = bin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            br[i] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                br[i] = br[i] | term;
            end
        end
        return br;
    endfunction

endpackage

// File: rtl/bgp_gen.sv
// Per-bit borrow generate/propagate cell for the lookahead subtractor.
module bgp_gen (
    input  logic a,
    input  logic b,
    output logic g_c,
    output logic p_c
);

    assign g_c = ~a & b;
    assign p_c = ~(a ^ b);

endmodule

// File: rtl/bla8_sub_pipe.sv
// Two-stage borrow-lookahead subtractor: low half in stage 1, high half, borrow out
// and signed overflow in stage 2, valid/ready on both sides at full throughput.
module bla8_sub_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned HALF = WIDTH / 2;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    cla_gp_t          gp_lo;
    cla_gp_t          gp_hi;
    logic [HALF-1:0]  br_lo;
    logic [HALF-1:0]  br_hi;
    logic [HALF-1:0]  d_lo;
    logic [HALF-1:0]  d_hi;

    logic             s2_ready;
    logic             accept;
    logic             s1_adv;

    logic             s1_valid_q, s1_valid_d;
    logic [HALF-1:0]  s1_dlo_q,   s1_dlo_d;
    logic             s1_br_q,    s1_br_d;
    logic [HALF-1:0]  s1_ahi_q,   s1_ahi_d;
    logic [HALF-1:0]  s1_bhi_q,   s1_bhi_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q,      diff_d;
    logic             bout_q,      bout_d;
    logic             ovf_q,       ovf_d;

    // Low cells see the live operands, high cells see the stage-1 registered high halves.
    assign op_a = {s1_ahi_q, a[HALF-1:0]};
    assign op_b = {s1_bhi_q, b[HALF-1:0]};

    bgp_gen u_bgp [WIDTH-1:0] (
        .a   (op_a),
        .b   (op_b),
        .g_c (g),
        .p_c (p)
    );

    always_comb begin
        gp_lo.g = CLA_W'(g[HALF-1:0]);
        gp_lo.p = CLA_W'(p[HALF-1:0]);
        gp_hi.g = CLA_W'(g[WIDTH-1:HALF]);
        gp_hi.p = CLA_W'(p[WIDTH-1:HALF]);

        br_lo = HALF'(bla_borrows(gp_lo.g, gp_lo.p, bin));
        br_hi = HALF'(bla_borrows(gp_hi.g, gp_hi.p, s1_br_q));

        // Borrow into each bit is the previous bit's borrow out, seeded at bit 0.
        d_lo = a[HALF-1:0] ^ b[HALF-1:0] ^ HALF'({br_lo, bin});
        d_hi = s1_ahi_q ^ s1_bhi_q ^ HALF'({br_hi, s1_br_q});
    end

    always_comb begin
        s2_ready = ~out_valid_q | out_ready;
        in_ready = rst_n & (~s1_valid_q | s2_ready);
        accept   = in_valid & in_ready;
        s1_adv   = s1_valid_q & s2_ready;

        s1_valid_d  = s1_valid_q;
        s1_dlo_d    = s1_dlo_q;
        s1_br_d     = s1_br_q;
        s1_ahi_d    = s1_ahi_q;
        s1_bhi_d    = s1_bhi_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_dlo_d   = d_lo;
            s1_br_d    = br_lo[HALF-1];
            s1_ahi_d   = a[WIDTH-1:HALF];
            s1_bhi_d   = b[WIDTH-1:HALF];
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            diff_d      = {d_hi, s1_dlo_q};
            bout_d      = br_hi[HALF-1];
            ovf_d       = (s1_ahi_q[HALF-1] ^ s1_bhi_q[HALF-1]) & (s1_ahi_q[HALF-1] ^ d_hi[HALF-1]);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_dlo_q    <= '0;
            s1_br_q     <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dlo_q    <= s1_dlo_d;
            s1_br_q     <= s1_br_d;
            s1_ahi_q    <= s1_ahi_d;
            s1_bhi_q    <= s1_bhi_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bla8_sub_pipe.sv
// Scoreboard bench for bla8_sub_pipe: directed vectors, latency, backpressure, reset, random stalls.
module tb_bla8_sub_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    typedef struct {
        logic [9:0] v;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   lat_chk = 1'b0;
    bit   rnd_on = 1'b0;

    bla8_sub_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Golden result packed as {bout, ovf, diff}.
    function automatic logic [9:0] model(input logic [7:0] ai, input logic [7:0] bi,
                                         input logic bini);
        logic [8:0] r;
        r = {1'b0, ai} - {1'b0, bi} - 9'(bini);
        return {r[8], (ai[7] ^ bi[7]) & (ai[7] ^ r[7]), r[7:0]};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one op (called just after a posedge) and push its expectation on accept.
    task automatic send(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                        input logic [9:0] ev);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ai;
        b = bi;
        bin = bini;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        else sb.push_back('{v: ev, acc: cyc});
        sync();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'({bout, ovf, diff}), 32'(e.v));
                if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd2);
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'({bout, ovf, diff}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed vectors, no backpressure, latency checked on each.
        lat_chk = 1'b1;
        sync();
        send(8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h02});
        drain();
        sync();
        send(8'h00, 8'h01, 1'b0, {1'b1, 1'b0, 8'hFF});
        drain();
        sync();
        send(8'h00, 8'h00, 1'b1, {1'b1, 1'b0, 8'hFF});
        drain();
        sync();
        send(8'h80, 8'h01, 1'b0, {1'b0, 1'b1, 8'h7F});
        drain();
        sync();
        send(8'h7F, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h80});
        drain();
        sync();
        check("idle_after_ops", 32'(out_valid), 32'd0);

        // Back-to-back ops drain on consecutive cycles.
        pop_cyc.delete();
        send(8'h10, 8'h01, 1'b0, model(8'h10, 8'h01, 1'b0));
        send(8'h0F, 8'h10, 1'b1, model(8'h0F, 8'h10, 1'b1));
        send(8'hF0, 8'h0F, 1'b1, model(8'hF0, 8'h0F, 1'b1));
        send(8'h33, 8'hCC, 1'b0, model(8'h33, 8'hCC, 1'b0));
        drain();
        check("b2b_count", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check("b2b_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
        end
        lat_chk = 1'b0;

        // Backpressure: two accepts fill the pipe, then hold.
        sync();
        out_ready = 1'b0;
        send(8'h9A, 8'h1B, 1'b1, model(8'h9A, 8'h1B, 1'b1));
        send(8'h44, 8'h55, 1'b0, model(8'h44, 8'h55, 1'b0));
        in_valid = 1'b1;
        a = 8'hC3;
        b = 8'h3C;
        bin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'({bout, ovf, diff}), 32'(model(8'h9A, 8'h1B, 1'b1)));
        end
        sync();
        out_ready = 1'b1;
        send(8'hC3, 8'h3C, 1'b1, model(8'hC3, 8'h3C, 1'b1));
        drain();

        // Reset with both stages full discards everything.
        sync();
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, model(8'h01, 8'h02, 1'b0));
        send(8'hAA, 8'h55, 1'b1, model(8'hAA, 8'h55, 1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_full_out_valid", 32'(out_valid), 32'd0);
        check("rst_full_diff", 32'(diff), 32'd0);
        check("rst_full_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        sync();
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(8'h5A, 8'hA5, 1'b0, model(8'h5A, 8'hA5, 1'b0));
        drain();
        lat_chk = 1'b0;

        // Random ops with random input gaps and output stalls.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    sync();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        sync();
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            if ($urandom_range(0, 3) == 0) sync();
            send(ra, rb, rc, model(ra, rb, rc));
        end
        rnd_on = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("final_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
